// File: rtl/mr_chips.sv
`default_nettype none
// ============================================================================
// Module   : mr_chips
// Purpose  : Single-cycle 16-bit RISC core. Each rising clock edge retires one
//            instruction: fetch from an internal ROM, decode, execute in the
//            ALU, and commit to PC, register file and data RAM.
// Ports    : clk        - system clock, all state updates on rising edge
//            reset      - asynchronous active-high; clears PC, registers, DMEM
//            pc_out     - byte address of the executing instruction
//            alu_result - combinational ALU output of the executing instruction
// Revision : 1.0 - initial release
// ============================================================================
module mr_chips #(
    parameter int IMEM_WORDS = 16,
    parameter int DMEM_WORDS = 16,
    parameter     IMEM_INIT  = "mr_chips_prog.hex"
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc_out,
    output logic [15:0] alu_result
);

    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_WORDS);

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_SLTI  = 4'b0110;
    localparam logic [3:0] OP_J     = 4'b0111;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;
    localparam logic [2:0] FN_SLL = 3'b101;
    localparam logic [2:0] FN_SRL = 3'b110;
    localparam logic [2:0] FN_SLT = 3'b111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] pc;
    logic [15:0] imem [IMEM_WORDS];
    logic [15:0] regs [8];
    logic [15:0] dmem [DMEM_WORDS];

    // Unloaded ROM words read as 0x0000 (NOP); contents may be filled by
    // whoever owns the hierarchy (e.g. a bench).
    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) begin
            imem[i] = 16'h0000;
        end
    end

    // ------------------------------------------------------------------
    // Fetch and decode
    // ------------------------------------------------------------------
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [2:0]  rd_addr;
    logic [2:0]  funct;
    logic [15:0] imm_sext;
    logic [11:0] target;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] pc_plus2;

    // Address aliases beyond the ROM depth because only pc[IA_W:1] is used.
    assign instr    = imem[pc[IA_W:1]];
    assign opcode   = instr[15:12];
    assign rs_addr  = instr[11:9];
    assign rt_addr  = instr[8:6];
    assign rd_addr  = instr[5:3];
    assign funct    = instr[2:0];
    assign imm_sext = {{10{instr[5]}}, instr[5:0]};
    assign target   = instr[11:0];

    // regs[0] is never written, so it always reads as zero.
    assign rs_val   = regs[rs_addr];
    assign rt_val   = regs[rt_addr];
    assign pc_plus2 = pc + 16'd2;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [15:0] alu;

    always_comb begin
        alu = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD: alu = rs_val + rt_val;
                    FN_SUB: alu = rs_val - rt_val;
                    FN_AND: alu = rs_val & rt_val;
                    FN_OR:  alu = rs_val | rt_val;
                    FN_XOR: alu = rs_val ^ rt_val;
                    FN_SLL: alu = rs_val << rt_val[3:0];
                    FN_SRL: alu = rs_val >> rt_val[3:0];
                    FN_SLT: alu = {15'd0, $signed(rs_val) < $signed(rt_val)};
                    default: alu = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu = rs_val + imm_sext;
            OP_BEQ, OP_BNE:        alu = rs_val - rt_val;
            OP_SLTI:               alu = {15'd0, $signed(rs_val) < $signed(imm_sext)};
            default:               alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control: write-back selection and next PC
    // ------------------------------------------------------------------
    logic          reg_we;
    logic [2:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          mem_we;
    logic [15:0]   next_pc;
    logic [DA_W-1:0] mem_idx;

    assign mem_idx = alu[DA_W:1];

    always_comb begin
        reg_we  = 1'b0;
        wr_addr = rt_addr;
        wr_data = alu;
        mem_we  = 1'b0;
        next_pc = pc_plus2;
        unique case (opcode)
            OP_RTYPE: begin
                reg_we  = 1'b1;
                wr_addr = rd_addr;
            end
            OP_ADDI, OP_SLTI: reg_we = 1'b1;
            OP_LW: begin
                reg_we  = 1'b1;
                wr_data = dmem[mem_idx];
            end
            OP_SW:  mem_we = 1'b1;
            // Branch compare is the ALU difference; offset counts words.
            OP_BEQ: if (alu == 16'd0) next_pc = pc_plus2 + {imm_sext[14:0], 1'b0};
            OP_BNE: if (alu != 16'd0) next_pc = pc_plus2 + {imm_sext[14:0], 1'b0};
            OP_J:   next_pc = {pc_plus2[15:13], target, 1'b0};
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc <= next_pc;
            if (reg_we && (wr_addr != 3'd0)) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= '0;
            end
        end else if (mem_we) begin
            dmem[mem_idx] <= rt_val;
        end
    end

    assign pc_out     = pc;
    assign alu_result = alu;

endmodule
`default_nettype wire

// File: tb/tb_mr_chips.sv
`default_nettype none
// ============================================================================
// Module   : tb_mr_chips
// Purpose  : Self-checking bench for mr_chips. Directed programs exercise
//            reset, arithmetic, memory, branches, jump/shifts and async reset;
//            random programs are compared cycle by cycle against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mr_chips;

    logic        clk;
    logic        reset;
    logic [15:0] pc_out;
    logic [15:0] alu_result;

    mr_chips #(
        .IMEM_WORDS(16),
        .DMEM_WORDS(16),
        .IMEM_INIT ("")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_out    (pc_out),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Instruction encoders
    // ------------------------------------------------------------------
    function automatic logic [15:0] enc_r(int rs, int rt, int rd, int fn);
        return {4'h0, 3'(rs), 3'(rt), 3'(rd), 3'(fn)};
    endfunction

    function automatic logic [15:0] enc_i(int op, int rs, int rt, int imm);
        return {4'(op), 3'(rs), 3'(rt), 6'(imm)};
    endfunction

    function automatic logic [15:0] enc_j(int t);
        return {4'h7, 12'(t)};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: an instruction interpreter over plain arrays
    // ------------------------------------------------------------------
    logic [15:0] prog   [16];
    logic [15:0] m_imem [16];
    logic [15:0] m_regs [8];
    logic [15:0] m_dmem [16];
    logic [15:0] m_pc;

    logic [15:0] obs_pc  [64];
    logic [15:0] obs_alu [64];

    function automatic int to_signed16(int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int imm_of(logic [15:0] ins);
        int v;
        v = int'(ins[5:0]);
        return (v >= 32) ? v - 64 : v;
    endfunction

    function automatic logic [15:0] m_alu(logic [15:0] ins);
        int op, a, b, imm, r, sh;
        op  = int'(ins[15:12]);
        a   = int'(m_regs[ins[11:9]]);
        b   = int'(m_regs[ins[8:6]]);
        imm = imm_of(ins);
        sh  = b % 16;
        r   = 0;
        case (op)
            0: case (int'(ins[2:0]))
                   0: r = a + b;
                   1: r = a - b;
                   2: r = a & b;
                   3: r = a | b;
                   4: r = a ^ b;
                   5: r = a * (1 << sh);
                   6: r = a / (1 << sh);
                   default: r = (to_signed16(a) < to_signed16(b)) ? 1 : 0;
               endcase
            1, 2, 3: r = a + imm;
            4, 5:    r = a - b;
            6:       r = (to_signed16(a) < imm) ? 1 : 0;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    function automatic logic [15:0] m_cur_instr();
        return m_imem[(int'(m_pc) / 2) % 16];
    endfunction

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 8; i++)  m_regs[i] = '0;
        for (int i = 0; i < 16; i++) m_dmem[i] = '0;
        for (int i = 0; i < 16; i++) m_imem[i] = prog[i];
    endtask

    task automatic model_step();
        logic [15:0] ins, res, nxt;
        int op, rt, rd, imm, addr;
        ins  = m_cur_instr();
        res  = m_alu(ins);
        op   = int'(ins[15:12]);
        rt   = int'(ins[8:6]);
        rd   = int'(ins[5:3]);
        imm  = imm_of(ins);
        addr = (int'(res) / 2) % 16;
        nxt  = m_pc + 16'd2;
        case (op)
            0: if (rd != 0) m_regs[rd] = res;
            1, 6: if (rt != 0) m_regs[rt] = res;
            2: if (rt != 0) m_regs[rt] = m_dmem[addr];
            3: m_dmem[addr] = m_regs[rt];
            4: if (m_regs[ins[11:9]] == m_regs[rt]) nxt = m_pc + 16'd2 + 16'(2 * imm);
            5: if (m_regs[ins[11:9]] != m_regs[rt]) nxt = m_pc + 16'd2 + 16'(2 * imm);
            7: nxt = ((m_pc + 16'd2) & 16'hE000) | 16'(int'(ins[11:0]) * 2);
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // ------------------------------------------------------------------
    // Program loading and execution
    // ------------------------------------------------------------------
    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    endtask

    // Must be called with reset asserted.
    task automatic load_prog();
        for (int i = 0; i < 16; i++) dut.imem[i] = prog[i];
    endtask

    // Called with reset high; checks the reset view, releases reset at a
    // falling edge and runs n instructions against the model. Leaves reset
    // asserted at a falling edge when end_in_reset is set.
    task automatic run_prog(input string name, input int n, input bit end_in_reset);
        model_reset();
        #1;
        check_val({name, "_rst_pc"}, pc_out, 16'h0000);
        check_val({name, "_rst_alu"}, alu_result, m_alu(m_cur_instr()));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            obs_pc[i]  = pc_out;
            obs_alu[i] = alu_result;
            check_val({name, "_pc"}, pc_out, m_pc);
            check_val({name, "_alu"}, alu_result, m_alu(m_cur_instr()));
            model_step();
            @(negedge clk);
        end
        if (end_in_reset) reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;

        // ---- Reset and fetch with an all-NOP ROM ----
        clear_prog();
        load_prog();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("reset_hold_pc", pc_out, 16'h0000);
        end
        run_prog("fetch", 4, 1'b1);
        check_val("fetch_pc1", obs_pc[1], 16'h0002);
        check_val("fetch_pc2", obs_pc[2], 16'h0004);
        check_val("fetch_pc3", obs_pc[3], 16'h0006);
        check_val("fetch_alu", obs_alu[2], 16'h0000);

        // ---- Arithmetic ----
        clear_prog();
        prog[0] = enc_i(1, 0, 1, 5);
        prog[1] = enc_i(1, 0, 2, -3);
        prog[2] = enc_r(1, 2, 3, 0);
        prog[3] = enc_r(1, 2, 4, 1);
        prog[4] = enc_r(2, 1, 5, 7);
        prog[5] = enc_r(3, 0, 6, 0);
        load_prog();
        run_prog("arith", 6, 1'b1);
        check_val("arith_addi", obs_alu[0], 16'h0005);
        check_val("arith_addi_neg", obs_alu[1], 16'hFFFD);
        check_val("arith_add", obs_alu[2], 16'h0002);
        check_val("arith_sub", obs_alu[3], 16'h0008);
        check_val("arith_slt", obs_alu[4], 16'h0001);
        check_val("arith_readback", obs_alu[5], 16'h0002);

        // ---- Memory, including address wrap to word 15 ----
        clear_prog();
        prog[0] = enc_i(1, 0, 1, 7);
        prog[1] = enc_i(3, 0, 1, 4);
        prog[2] = enc_i(2, 0, 2, 4);
        prog[3] = enc_r(2, 2, 3, 0);
        prog[4] = enc_i(1, 0, 1, 11);
        prog[5] = enc_i(3, 0, 1, -2);
        prog[6] = enc_i(2, 0, 4, 30);
        prog[7] = enc_r(4, 0, 5, 0);
        prog[8] = enc_i(2, 0, 6, -2);
        prog[9] = enc_r(6, 0, 7, 0);
        load_prog();
        run_prog("mem", 10, 1'b1);
        check_val("mem_sw_addr", obs_alu[1], 16'h0004);
        check_val("mem_lw_addr", obs_alu[2], 16'h0004);
        check_val("mem_lw_use", obs_alu[3], 16'h000E);
        check_val("mem_wrap_addr", obs_alu[5], 16'hFFFE);
        check_val("mem_wrap_alias", obs_alu[7], 16'h000B);
        check_val("mem_wrap_lw", obs_alu[9], 16'h000B);

        // ---- Branches at PC 0x0006 ----
        clear_prog();
        prog[0] = enc_i(1, 0, 1, 3);
        prog[3] = enc_i(4, 1, 1, 2);
        load_prog();
        run_prog("beq", 5, 1'b1);
        check_val("beq_at", obs_pc[3], 16'h0006);
        check_val("beq_taken", obs_pc[4], 16'h000C);

        prog[3] = enc_i(5, 1, 1, 2);
        load_prog();
        run_prog("bne", 5, 1'b1);
        check_val("bne_not_taken", obs_pc[4], 16'h0008);

        prog[3] = enc_i(4, 1, 1, -1);
        load_prog();
        run_prog("bloop", 6, 1'b1);
        check_val("beq_self1", obs_pc[4], 16'h0006);
        check_val("beq_self2", obs_pc[5], 16'h0006);

        // ---- Jump and shifts ----
        clear_prog();
        prog[0] = enc_j(3);
        prog[3] = enc_i(1, 0, 1, 1);
        prog[4] = enc_i(1, 0, 2, 15);
        prog[5] = enc_r(1, 2, 3, 5);
        prog[6] = enc_r(3, 2, 4, 6);
        load_prog();
        run_prog("jmp", 5, 1'b1);
        check_val("jmp_alu", obs_alu[0], 16'h0000);
        check_val("jmp_target", obs_pc[1], 16'h0006);
        check_val("sll", obs_alu[3], 16'h8000);
        check_val("srl", obs_alu[4], 16'h0001);

        // ---- Async reset mid-run ----
        clear_prog();
        prog[0] = enc_i(1, 0, 1, 5);
        prog[1] = enc_i(1, 0, 2, -3);
        prog[2] = enc_r(1, 2, 3, 0);
        prog[3] = enc_r(1, 2, 4, 1);
        load_prog();
        run_prog("pre_async", 3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_pc", pc_out, 16'h0000);
        clear_prog();
        prog[0] = enc_r(1, 2, 3, 0);
        prog[1] = enc_i(1, 0, 0, 9);
        prog[2] = enc_r(0, 0, 1, 0);
        prog[3] = enc_i(2, 0, 2, 4);
        prog[4] = enc_r(2, 2, 3, 0);
        load_prog();
        run_prog("post_async", 5, 1'b1);
        check_val("post_add", obs_alu[0], 16'h0000);
        check_val("post_addi_r0", obs_alu[1], 16'h0009);
        check_val("post_r0_zero", obs_alu[2], 16'h0000);
        check_val("post_dmem_clr", obs_alu[4], 16'h0000);

        // ---- Random programs against the reference model ----
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 16; i++) begin
                // Bias toward ADDI so registers carry interesting values.
                if ($urandom_range(0, 3) == 0)
                    prog[i] = enc_i(1, $urandom_range(0, 7), $urandom_range(0, 7),
                                    $urandom_range(0, 63));
                else
                    prog[i] = 16'($urandom);
            end
            load_prog();
            run_prog("rnd", 30, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
